// File: rtl/exec_pkg.sv
// Shared opcode constants, default datapath width and unit state encoding for
// the execute unit and the reservation station that feeds it.
package exec_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_BNE   = 4'b0111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  typedef struct packed {
    logic [2:0] rob_tag;
    logic [3:0] rd_tag;
  } tag_t;

endpackage

// File: rtl/exec_div.sv
// Iterative restoring divider: one quotient bit per clock, valid (combinational)
// is high for the single cycle after the last quotient bit has been shifted in.
module exec_div
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic              dbz,
  output logic              valid
);

  localparam int CW = $clog2(DATA_W + 1);

  logic              r_active;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_dvs_ext;
  logic              w_ge;

  // Remainder shifted left with the next dividend bit brought in from the top of r_quo.
  assign w_shift   = {r_rem, r_quo[DATA_W-1]};
  assign w_dvs_ext = {1'b0, r_dvs};
  assign w_ge      = (w_shift >= w_dvs_ext);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= CW'(DATA_W);
      r_rem    <= '0;
      r_quo    <= dividend;
      r_dvs    <= divisor;
    end else if (r_active && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
      if (w_ge) begin
        r_rem <= DATA_W'(w_shift - w_dvs_ext);
        r_quo <= {r_quo[DATA_W-2:0], 1'b1};
      end else begin
        r_rem <= w_shift[DATA_W-1:0];
        r_quo <= {r_quo[DATA_W-2:0], 1'b0};
      end
    end else if (r_active) begin
      r_active <= 1'b0;
    end
  end

  assign quotient = r_quo;
  assign dbz      = (r_dvs == '0);
  assign valid    = r_active && (r_cnt == '0);

endmodule

// File: rtl/exec.sv
// Execute unit: single-cycle ALU/address/branch ops, a fixed-latency multiply and
// an iterative divide. One op in flight; completions are registered one-cycle pulses.
// Handshake: an op is taken on a clk1 edge where exec_b=1 and busy=0; exec_b is
// ignored while busy=1; done pulses once per taken op and the result fields hold
// until the next done. MUL_LAT must be at least 2.
module exec
  import exec_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rs1data,
  input  logic [DATA_W-1:0] rs2data,
  input  logic [3:0]        func,
  input  logic [2:0]        rob_ind,
  input  logic [3:0]        rd,
  input  logic              exec_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        res_rob,
  output logic [3:0]        res_rd,
  output logic              flag,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(MUL_LAT + 1);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_prod;
  tag_t              r_tag;
  logic              r_done;
  logic [DATA_W-1:0] r_result;
  logic [2:0]        r_res_rob;
  logic [3:0]        r_res_rd;
  logic              r_flag;

  logic [DATA_W-1:0] w_sc_result;
  logic              w_sc_flag;
  logic [DATA_W-1:0] w_prod;
  logic              w_div_start;
  logic [DATA_W-1:0] w_div_quo;
  logic              w_div_dbz;
  logic              w_div_valid;

  assign w_prod      = rs1data * rs2data;
  assign w_div_start = exec_b && (r_state == ST_IDLE) && (func == OP_DIV);

  exec_div #(.DATA_W(DATA_W)) u_div (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (rs1data),
    .divisor  (rs2data),
    .quotient (w_div_quo),
    .dbz      (w_div_dbz),
    .valid    (w_div_valid)
  );

  // Single-cycle datapath; anything that is not a known opcode reports flag=1.
  always_comb begin
    w_sc_result = '0;
    w_sc_flag   = 1'b0;
    case (func)
      OP_ADD, OP_LOAD, OP_STORE: w_sc_result = rs1data + rs2data;
      OP_SUB:                    w_sc_result = rs1data - rs2data;
      OP_BEQ:                    w_sc_flag   = (rs1data == rs2data);
      OP_BNE:                    w_sc_flag   = (rs1data != rs2data);
      default:                   w_sc_flag   = 1'b1;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_prod    <= '0;
      r_tag     <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_res_rob <= '0;
      r_res_rd  <= '0;
      r_flag    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (exec_b) begin
            r_tag <= '{rob_tag: rob_ind, rd_tag: rd};
            if (func == OP_MUL) begin
              r_state <= ST_MUL;
              r_cnt   <= CW'(MUL_LAT - 1);
              r_prod  <= w_prod;
            end else if (func == OP_DIV) begin
              r_state <= ST_DIV;
            end else begin
              r_done    <= 1'b1;
              r_result  <= w_sc_result;
              r_flag    <= w_sc_flag;
              r_res_rob <= rob_ind;
              r_res_rd  <= rd;
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_result  <= r_prod;
            r_flag    <= 1'b0;
            r_res_rob <= r_tag.rob_tag;
            r_res_rd  <= r_tag.rd_tag;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (w_div_valid) begin
            r_state   <= ST_IDLE;
            r_done    <= 1'b1;
            r_result  <= w_div_dbz ? {DATA_W{1'b1}} : w_div_quo;
            r_flag    <= w_div_dbz;
            r_res_rob <= r_tag.rob_tag;
            r_res_rd  <= r_tag.rd_tag;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign result    = r_result;
  assign res_rob   = r_res_rob;
  assign res_rd    = r_res_rd;
  assign flag      = r_flag;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_exec.sv
// Bench for exec: fixed vector table, hand-written multi-cycle sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_exec;

  localparam int W  = 16;
  localparam int ML = 3;

  logic         clk1 = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] rs1data, rs2data;
  logic [3:0]   func, rd;
  logic [2:0]   rob_ind;
  logic         exec_b;
  logic         busy, done, flag;
  logic [W-1:0] result;
  logic [2:0]   res_rob;
  logic [3:0]   res_rd;
  logic [1:0]   dbg_state;

  exec #(.DATA_W(W), .MUL_LAT(ML)) dut (
    .clk1(clk1), .rst_n(rst_n), .rs1data(rs1data), .rs2data(rs2data),
    .func(func), .rob_ind(rob_ind), .rd(rd), .exec_b(exec_b),
    .busy(busy), .done(done), .result(result), .res_rob(res_rob),
    .res_rd(res_rd), .flag(flag), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;
  int free_cyc = 0;

  typedef struct {
    int           at_cyc;
    logic [W-1:0] res;
    logic         flg;
    logic [2:0]   rob;
    logic [3:0]   rdt;
  } exp_t;

  exp_t exp_q[$];
  exp_t e0;

  typedef struct {
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   rb;
    logic [3:0]   rdt;
    logic [W-1:0] er;
    logic         ef;
    int           lat;
  } vec_t;

  vec_t tbl[15];

  logic [W-1:0] last_res;
  logic         last_flag;
  logic [2:0]   last_rob;
  logic [3:0]   last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp_v, cyc);
    end
  endtask

  // reference model
  function automatic logic [W-1:0] ref_res(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x = a;
    int unsigned y = b;
    case (f)
      4'd0, 4'd4, 4'd5: return W'((x + y) % 65536);
      4'd1:             return W'((x + 65536 - y) % 65536);
      4'd2:             return W'((x * y) % 65536);
      4'd3:             return (y == 0) ? 16'hFFFF : W'(x / y);
      default:          return '0;
    endcase
  endfunction

  function automatic logic ref_flag(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    case (f)
      4'd0, 4'd1, 4'd2, 4'd4, 4'd5: return 1'b0;
      4'd3:    return (b == 0);
      4'd6:    return (a == b);
      4'd7:    return (a != b);
      default: return 1'b1;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] f);
    if (f == 4'd2) return ML;
    if (f == 4'd3) return W + 1;
    return 0;
  endfunction

  // scoreboard / monitor, sampled 1 time unit after each rising edge
  always @(posedge clk1) begin
    #1;
    if (!rst_n) begin
      last_res = '0; last_flag = 1'b0; last_rob = '0; last_rd = '0;
    end else begin
      chk("busy", 32'(busy), 32'(cyc + 1 < free_cyc));
      while (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
        chk("missed_done", 32'(cyc), 32'(exp_q[0].at_cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].at_cyc == cyc) begin
        chk("done", 32'(done), 32'd1);
        chk("result", 32'(result), 32'(exp_q[0].res));
        chk("flag", 32'(flag), 32'(exp_q[0].flg));
        chk("res_rob", 32'(res_rob), 32'(exp_q[0].rob));
        chk("res_rd", 32'(res_rd), 32'(exp_q[0].rdt));
        last_res = exp_q[0].res; last_flag = exp_q[0].flg;
        last_rob = exp_q[0].rob; last_rd = exp_q[0].rdt;
        void'(exp_q.pop_front());
      end else begin
        chk("no_done", 32'(done), 32'd0);
        chk("hold", 32'({result, flag, res_rob, res_rd}), 32'({last_res, last_flag, last_rob, last_rd}));
      end
    end
  end

  // driver tasks: inputs change 3 time units after a rising edge
  task automatic drive(input logic en, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] rb, input logic [3:0] rdt,
                       input logic [W-1:0] er, input logic ef, input int elat);
    exp_t e;
    @(posedge clk1); #3;
    exec_b = en; func = f; rs1data = a; rs2data = b; rob_ind = rb; rd = rdt;
    if (en && (cyc + 1 >= free_cyc)) begin
      e.at_cyc = cyc + 1 + elat; e.res = er; e.flg = ef; e.rob = rb; e.rdt = rdt;
      exp_q.push_back(e);
      free_cyc = e.at_cyc + 1;
    end
  endtask

  task automatic model_drive(input logic en, input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] rb, input logic [3:0] rdt);
    drive(en, f, a, b, rb, rdt, ref_res(f, a, b), ref_flag(f, a, b), ref_lat(f));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk1); #3;
      exec_b = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      idle(1);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    idle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   f;
    logic [W-1:0] a, b;
    int           sel;

    exec_b = 1'b0; func = '0; rs1data = '0; rs2data = '0; rob_ind = '0; rd = '0;

    tbl[0]  = '{4'h0, 16'h0005, 16'h0003, 3'd2, 4'd4,  16'h0008, 1'b0, 0};
    tbl[1]  = '{4'h1, 16'h0000, 16'h0001, 3'd1, 4'd1,  16'hFFFF, 1'b0, 0};
    tbl[2]  = '{4'h6, 16'h0007, 16'h0007, 3'd3, 4'd2,  16'h0000, 1'b1, 0};
    tbl[3]  = '{4'h7, 16'h0007, 16'h0007, 3'd4, 4'd3,  16'h0000, 1'b0, 0};
    tbl[4]  = '{4'h2, 16'h0100, 16'h0101, 3'd5, 4'd5,  16'h0100, 1'b0, 3};
    tbl[5]  = '{4'h3, 16'd100,  16'd7,    3'd6, 4'd6,  16'd14,   1'b0, 17};
    tbl[6]  = '{4'h3, 16'd5,    16'd0,    3'd7, 4'd7,  16'hFFFF, 1'b1, 17};
    tbl[7]  = '{4'hA, 16'h1234, 16'h5678, 3'd1, 4'd8,  16'h0000, 1'b1, 0};
    tbl[8]  = '{4'h4, 16'hFFF0, 16'h0020, 3'd2, 4'd9,  16'h0010, 1'b0, 0};
    tbl[9]  = '{4'h5, 16'h1234, 16'h1111, 3'd3, 4'd10, 16'h2345, 1'b0, 0};
    tbl[10] = '{4'h6, 16'h0001, 16'h0002, 3'd4, 4'd11, 16'h0000, 1'b0, 0};
    tbl[11] = '{4'h7, 16'h0001, 16'h0002, 3'd5, 4'd12, 16'h0000, 1'b1, 0};
    tbl[12] = '{4'h2, 16'hFFFF, 16'hFFFF, 3'd6, 4'd13, 16'h0001, 1'b0, 3};
    tbl[13] = '{4'h3, 16'hFFFF, 16'h0001, 3'd7, 4'd14, 16'hFFFF, 1'b0, 17};
    tbl[14] = '{4'h3, 16'h0003, 16'h0009, 3'd0, 4'd15, 16'h0000, 1'b0, 17};

    // reset
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", 32'({result, res_rob, res_rd, flag}), 32'd0);
    repeat (3) @(posedge clk1);
    #3 rst_n = 1'b1;

    // table vectors
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].rb, tbl[i].rdt, tbl[i].er, tbl[i].ef, tbl[i].lat);
      drain();
    end

    // back-to-back single-cycle issues
    for (int i = 0; i < 6; i++)
      model_drive(1'b1, 4'(i % 2), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 3'(i), 4'(i));
    drain();

    // mul, adds while busy are ignored, add in the done cycle is taken
    drive(1'b1, 4'h2, 16'h0100, 16'h0101, 3'd2, 4'd7, 16'h0100, 1'b0, ML);
    for (int i = 0; i < ML + 1; i++)
      model_drive(1'b1, 4'h0, 16'(i + 1), 16'h0010, 3'd3, 4'd9);
    drain();

    // reset in the middle of a divide
    model_drive(1'b1, 4'h0, 16'h0005, 16'h0003, 3'd2, 4'd4);
    model_drive(1'b1, 4'h3, 16'd1000, 16'd3, 3'd5, 4'd6);
    idle(5);
    @(posedge clk1); #3;
    rst_n = 1'b0;
    exec_b = 1'b0;
    exp_q.delete();
    free_cyc = 0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_outs", 32'({result, res_rob, res_rd, flag}), 32'd0);
    idle(2);
    @(posedge clk1); #3;
    rst_n = 1'b1;
    exec_b = 1'b1; func = 4'h0; rs1data = 16'h0021; rs2data = 16'h0012; rob_ind = 3'd1; rd = 4'd3;
    e0.at_cyc = cyc + 1; e0.res = 16'h0033; e0.flg = 1'b0; e0.rob = 3'd1; e0.rdt = 4'd3;
    exp_q.push_back(e0);
    free_cyc = e0.at_cyc + 1;
    drain();
    idle(25);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a = 16'($urandom_range(0, 65535));
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = '0;
      else if (sel == 1) b = a;
      else if (sel == 2) b = 16'($urandom_range(1, 15));
      else               b = 16'($urandom_range(0, 65535));
      model_drive(1'($urandom_range(0, 3) != 0), f, a, b, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
